// File: rtl/deserializer_if.sv
// Serial-in / word-out bundle of the deserializer.
// slave: deserializer side (takes bit stream + ready, drives words and status).
// master: environment side (drives bit stream + ready, observes words and status).
interface deserializer_if #(
  parameter int WIDTH = 16
);
  localparam int MW = $clog2(WIDTH) + 1;

  logic             ser_data_i;
  logic             ser_data_val_i;
  logic [WIDTH-1:0] data_o;
  logic [MW-1:0]    data_mod_o;
  logic             data_val_o;
  logic             data_ready_i;
  logic             busy_o;
  logic             overflow_o;

  modport slave (
    input  ser_data_i, ser_data_val_i, data_ready_i,
    output data_o, data_mod_o, data_val_o, busy_o, overflow_o
  );

  modport master (
    output ser_data_i, ser_data_val_i, data_ready_i,
    input  data_o, data_mod_o, data_val_o, busy_o, overflow_o
  );
endinterface

// File: rtl/deserializer.sv
// Purpose: collect an MSB-first serial stream into WIDTH-bit words; short frames closed by idle gap.
// Latency: word visible at FIFO head the cycle after the edge that completes/flushes the frame.
// Backpressure: FIFO_DEPTH-entry show-ahead FIFO; a push into a full FIFO without a pop is dropped, overflow_o sticks.
// Ports: clk_i, srst_n_i (sync, active-low); bus (slave modport) carries serial input,
//        data_o/data_mod_o/data_val_o/data_ready_i word handshake, busy_o, overflow_o.
module deserializer #(
  parameter int WIDTH      = 16,
  parameter int GAP_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk_i,
  input logic           srst_n_i,
  deserializer_if.slave bus
);
  localparam int MW = $clog2(WIDTH) + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [MW-1:0] WIDTH_M  = MW'(WIDTH);
  localparam logic [MW-1:0] LAST_BIT = MW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef struct packed {
    logic [MW-1:0]    mod;
    logic [WIDTH-1:0] dat;
  } entry_t;

  // Capture state: shifter holds received bits right-aligned (newest in bit 0).
  logic [WIDTH-1:0] shifter;
  logic [MW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;

  logic   push_vld;
  entry_t push_ent;

  // FIFO state
  entry_t      mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr_en;
  logic        overflow;
  entry_t      head;

  // Frame completion: either the WIDTH-th bit arrives, or the idle gap expires.
  always_comb begin
    push_vld = 1'b0;
    push_ent = '0;
    if (bus.ser_data_val_i) begin
      if (bit_cnt == LAST_BIT) begin
        push_vld     = 1'b1;
        push_ent.dat = {shifter[WIDTH-2:0], bus.ser_data_i};
        push_ent.mod = WIDTH_M;
      end
    end else if (bit_cnt != '0 && gap_cnt == GAP_LAST) begin
      push_vld     = 1'b1;
      // Left-align the partial frame; stale bits of earlier frames shift out the top.
      push_ent.dat = shifter << (WIDTH_M - bit_cnt);
      push_ent.mod = bit_cnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      shifter <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else if (bus.ser_data_val_i) begin
      shifter <= {shifter[WIDTH-2:0], bus.ser_data_i};
      gap_cnt <= '0;
      bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + MW'(1);
    end else if (bit_cnt != '0) begin
      if (gap_cnt == GAP_LAST) begin
        bit_cnt <= '0;
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + GW'(1);
      end
    end
  end

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = !empty && bus.data_ready_i;
  // A pop frees the head slot on the same edge, so a push at full is still accepted.
  assign wr_en = push_vld && (!full || pop);

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)   rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push_vld && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= push_ent;
  end

  // Storage is not reset; the head is masked while empty so outputs read zero.
  assign head           = mem[rd_ptr[AW-1:0]];
  assign bus.data_o     = empty ? '0 : head.dat;
  assign bus.data_mod_o = empty ? '0 : head.mod;
  assign bus.data_val_o = !empty;
  assign bus.busy_o     = (bit_cnt != '0);
  assign bus.overflow_o = overflow;
endmodule

// File: tb/tb_deserializer.sv
module tb_deserializer;
  logic clk;
  logic srst_n;
  int   total;
  int   bad;

  deserializer_if #(.WIDTH(16)) bus ();

  deserializer #(
    .WIDTH(16),
    .GAP_CYCLES(4),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_i   (clk),
    .srst_n_i(srst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sends the first n bits of w, MSB first, then goes idle with X on the data line.
  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ser_data_val_i = 1'b1;
      bus.ser_data_i     = w[15-i];
      tick();
    end
    bus.ser_data_val_i = 1'b0;
    bus.ser_data_i     = 1'bx;
  endtask

  logic [15:0] frames6 [3];
  logic [15:0] heads6  [3];
  logic [15:0] drain6  [4];

  initial begin
    total = 0;
    bad   = 0;
    frames6 = '{16'h5555, 16'h6666, 16'h7777};
    heads6  = '{16'h2222, 16'h3333, 16'h4444};
    drain6  = '{16'h4444, 16'h5555, 16'h6666, 16'h7777};

    srst_n             = 1'b0;
    bus.ser_data_i     = 1'b0;
    bus.ser_data_val_i = 1'b0;
    bus.data_ready_i   = 1'b1;
    tick();
    tick();
    srst_n = 1'b1;
    chk("rst_val",  {31'd0, bus.data_val_o}, 32'd0);
    chk("rst_data", {16'd0, bus.data_o},     32'd0);
    chk("rst_mod",  {27'd0, bus.data_mod_o}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy_o},     32'd0);
    chk("rst_ovf",  {31'd0, bus.overflow_o}, 32'd0);

    // Full 16-bit frame
    send_bits(16'hC501, 15);
    chk("t1_busy_mid", {31'd0, bus.busy_o},     32'd1);
    chk("t1_val_mid",  {31'd0, bus.data_val_o}, 32'd0);
    bus.ser_data_val_i = 1'b1;
    bus.ser_data_i     = 1'b1;  // bit 0 of C501
    tick();
    bus.ser_data_val_i = 1'b0;
    chk("t1_val",  {31'd0, bus.data_val_o}, 32'd1);
    chk("t1_data", {16'd0, bus.data_o},     32'h0000_C501);
    chk("t1_mod",  {27'd0, bus.data_mod_o}, 32'd16);
    chk("t1_busy", {31'd0, bus.busy_o},     32'd0);
    tick();
    chk("t1_drained", {31'd0, bus.data_val_o}, 32'd0);

    // Partial frame 1100 flushed by 4 idle cycles
    send_bits(16'hC000, 4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_gap_busy", {31'd0, bus.busy_o},     32'd1);
      chk("t2_gap_val",  {31'd0, bus.data_val_o}, 32'd0);
    end
    tick();
    chk("t2_val",  {31'd0, bus.data_val_o}, 32'd1);
    chk("t2_data", {16'd0, bus.data_o},     32'h0000_C000);
    chk("t2_mod",  {27'd0, bus.data_mod_o}, 32'd4);
    chk("t2_busy", {31'd0, bus.busy_o},     32'd0);
    tick();
    chk("t2_drained", {31'd0, bus.data_val_o}, 32'd0);

    // Short gap does not split the frame: 10 .. 11 -> B000/4
    send_bits(16'h8000, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_gap1_val", {31'd0, bus.data_val_o}, 32'd0);
    end
    send_bits(16'hC000, 2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_gap2_val", {31'd0, bus.data_val_o}, 32'd0);
    end
    tick();
    chk("t3_val",  {31'd0, bus.data_val_o}, 32'd1);
    chk("t3_data", {16'd0, bus.data_o},     32'h0000_B000);
    chk("t3_mod",  {27'd0, bus.data_mod_o}, 32'd4);
    tick();
    chk("t3_drained", {31'd0, bus.data_val_o}, 32'd0);

    // Overflow: 5 words into a 4-deep FIFO with ready low
    bus.data_ready_i = 1'b0;
    send_bits(16'h0001, 16);
    send_bits(16'h0002, 16);
    send_bits(16'h0003, 16);
    send_bits(16'h0004, 16);
    chk("t4_ovf_before", {31'd0, bus.overflow_o}, 32'd0);
    send_bits(16'h0005, 16);
    chk("t4_ovf",  {31'd0, bus.overflow_o}, 32'd1);
    chk("t4_hold", {16'd0, bus.data_o},     32'h0000_0001);
    bus.data_ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk("t4_drain_val",  {31'd0, bus.data_val_o}, 32'd1);
      chk("t4_drain_data", {16'd0, bus.data_o},     32'(k));
      tick();
    end
    chk("t4_empty",     {31'd0, bus.data_val_o}, 32'd0);
    chk("t4_ovf_stick", {31'd0, bus.overflow_o}, 32'd1);

    // Reset mid-frame discards the partial frame and clears overflow
    send_bits(16'hFFFF, 7);
    chk("t5_busy_pre", {31'd0, bus.busy_o}, 32'd1);
    srst_n = 1'b0;
    tick();
    srst_n = 1'b1;
    chk("t5_val",  {31'd0, bus.data_val_o}, 32'd0);
    chk("t5_data", {16'd0, bus.data_o},     32'd0);
    chk("t5_mod",  {27'd0, bus.data_mod_o}, 32'd0);
    chk("t5_busy", {31'd0, bus.busy_o},     32'd0);
    chk("t5_ovf",  {31'd0, bus.overflow_o}, 32'd0);
    for (int i = 0; i < 5; i++) tick();
    chk("t5_no_flush", {31'd0, bus.data_val_o}, 32'd0);
    send_bits(16'hA5A5, 16);
    chk("t5_word_val",  {31'd0, bus.data_val_o}, 32'd1);
    chk("t5_word_data", {16'd0, bus.data_o},     32'h0000_A5A5);
    chk("t5_word_mod",  {27'd0, bus.data_mod_o}, 32'd16);
    tick();
    chk("t5_single", {31'd0, bus.data_val_o}, 32'd0);

    // Full FIFO, pop coincides with each push: no loss, order kept
    bus.data_ready_i = 1'b0;
    send_bits(16'h1111, 16);
    send_bits(16'h2222, 16);
    send_bits(16'h3333, 16);
    send_bits(16'h4444, 16);
    chk("t6_head0", {16'd0, bus.data_o}, 32'h0000_1111);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 16; i++) begin
        bus.ser_data_val_i = 1'b1;
        bus.ser_data_i     = frames6[f][15-i];
        bus.data_ready_i   = (i == 15);
        tick();
      end
      bus.ser_data_val_i = 1'b0;
      bus.data_ready_i   = 1'b0;
      chk("t6_head", {16'd0, bus.data_o},     {16'd0, heads6[f]});
      chk("t6_ovf",  {31'd0, bus.overflow_o}, 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t6_held", {16'd0, bus.data_o}, {16'd0, drain6[k]});
      bus.data_ready_i = 1'b1;
      chk("t6_drain_val",  {31'd0, bus.data_val_o}, 32'd1);
      chk("t6_drain_data", {16'd0, bus.data_o},     {16'd0, drain6[k]});
      tick();
      bus.data_ready_i = 1'b0;
    end
    chk("t6_empty",   {31'd0, bus.data_val_o}, 32'd0);
    chk("t6_ovf_end", {31'd0, bus.overflow_o}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
